// File: rtl/cpu_dbg_ctrl.sv
// cpu_dbg_ctrl: reset/run/halt/step sequencer for the 16-bit cpu, lending the memory port to the host while halted.
module cpu_dbg_ctrl #(
    parameter int AWIDTH     = 16,
    parameter int DWIDTH     = 16,
    parameter int RST_CYCLES = 4,
    parameter bit BOOT_RUN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [AWIDTH-1:0] cmd_addr_i,
    input  logic [DWIDTH-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic              halted_o,
    output logic              cpu_en_o,
    output logic              cpu_rst_o,
    input  logic [AWIDTH-1:0] cpu_raddr_i,
    input  logic [AWIDTH-1:0] cpu_waddr_i,
    input  logic [DWIDTH-1:0] cpu_wdata_i,
    input  logic              cpu_wr_i,
    input  logic              cpu_rd_i,
    output logic [AWIDTH-1:0] mem_raddr_o,
    output logic [AWIDTH-1:0] mem_waddr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_wr_o,
    output logic              mem_rd_o,
    input  logic [DWIDTH-1:0] mem_rdata_i
);
    typedef enum logic [2:0] {CRST, RESUME, RUN, HALT, STEP, HRD, HRD2, HWR} state_t;

    localparam logic [2:0] OP_HALT  = 3'd1;
    localparam logic [2:0] OP_RUN   = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_RESET = 3'd4;
    localparam logic [2:0] OP_READ  = 3'd5;
    localparam logic [2:0] OP_WRITE = 3'd6;
    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

    state_t            state, state_nx;
    logic [7:0]        rcnt, rcnt_nx;
    logic [15:0]       scnt, scnt_nx;
    logic              boot, boot_nx;
    logic              to_step, to_step_nx;
    logic              rsp_v, rsp_e;
    logic              fire, cpu_side;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;

    assign cpu_rst_o   = state == CRST;
    assign cpu_en_o    = state inside {CRST, RUN, STEP};
    assign halted_o    = state == HALT;
    assign cmd_ready_o = state inside {RUN, HALT} || (state == STEP && cmd_op_i == OP_HALT);
    assign fire        = cmd_valid_i && cmd_ready_o;

    // RESUME keeps the CPU's fetch address on the port so read data is valid when it re-enables
    assign cpu_side    = cpu_en_o || state == RESUME;
    assign mem_raddr_o = cpu_side ? cpu_raddr_i : addr;
    assign mem_waddr_o = cpu_side ? cpu_waddr_i : addr;
    assign mem_wdata_o = cpu_side ? cpu_wdata_i : data;
    assign mem_wr_o    = cpu_side ? cpu_wr_i && cpu_en_o && state != CRST : state == HWR;
    assign mem_rd_o    = 1'b1 | cpu_rd_i;

    always_comb begin
        state_nx   = state;
        rcnt_nx    = 8'd0;
        scnt_nx    = scnt;
        boot_nx    = boot;
        to_step_nx = to_step;
        rsp_v      = 1'b0;
        rsp_e      = 1'b0;
        case (state)
            CRST: begin
                if (rcnt == RST_LAST) begin
                    state_nx   = (boot && BOOT_RUN) ? RESUME : HALT;
                    boot_nx    = boot && BOOT_RUN;
                    rsp_v      = !boot;
                    to_step_nx = 1'b0;
                end else begin
                    rcnt_nx = rcnt + 8'd1;
                end
            end
            RESUME: begin
                state_nx = to_step ? STEP : RUN;
                rsp_v    = !boot && !to_step;
                boot_nx  = 1'b0;
            end
            RUN: begin
                if (fire) begin
                    state_nx = (cmd_op_i == OP_HALT) ? HALT : (cmd_op_i == OP_RESET) ? CRST : RUN;
                    rsp_v    = cmd_op_i != OP_RESET;
                    rsp_e    = cmd_op_i inside {OP_RUN, OP_STEP, OP_READ, OP_WRITE};
                end
            end
            HALT: begin
                if (fire) begin
                    case (cmd_op_i)
                        OP_RUN:   begin state_nx = RESUME; to_step_nx = 1'b0; end
                        OP_STEP: begin
                            state_nx   = RESUME;
                            to_step_nx = 1'b1;
                            scnt_nx    = (cmd_data_i == '0) ? 16'd1 : 16'(cmd_data_i);
                        end
                        OP_RESET: state_nx = CRST;
                        OP_READ:  state_nx = HRD;
                        OP_WRITE: state_nx = HWR;
                        default:  rsp_v = 1'b1;
                    endcase
                end
            end
            STEP: begin
                state_nx = (fire || scnt == 16'd1) ? HALT : STEP;
                rsp_v    = fire || scnt == 16'd1;
                scnt_nx  = scnt - 16'd1;
            end
            HRD: state_nx = HRD2;
            HRD2, HWR: begin
                state_nx = HALT;
                rsp_v    = 1'b1;
            end
            default: state_nx = CRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= CRST;
            rcnt        <= 8'd0;
            scnt        <= 16'd0;
            boot        <= 1'b1;
            to_step     <= 1'b0;
            addr        <= '0;
            data        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            state       <= state_nx;
            rcnt        <= rcnt_nx;
            scnt        <= scnt_nx;
            boot        <= boot_nx;
            to_step     <= to_step_nx;
            rsp_valid_o <= rsp_v;
            rsp_err_o   <= rsp_e;
            if (fire) begin
                addr <= cmd_addr_i;
                data <= cmd_data_i;
            end
            if (state == HRD2) rsp_data_o <= mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
// tb_cpu_dbg_ctrl: table vectors, hand sequences and a randomized command stream for cpu_dbg_ctrl.
module tb_cpu_dbg_ctrl;
    localparam int RC = 4;
    localparam logic [2:0] NOP = 3'd0, HLT = 3'd1, RUNC = 3'd2, STP = 3'd3;
    localparam logic [2:0] RST = 3'd4, RD = 3'd5, WR = 3'd6, BAD = 3'd7;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_addr = 16'd0, cmd_data = 16'd0;
    logic        rsp_valid, rsp_err, halted, cpu_en, cpu_rst;
    logic [15:0] rsp_data;
    logic [15:0] cpu_raddr = 16'h1234, cpu_waddr = 16'h00F0, cpu_wdata = 16'h1111;
    logic        cpu_wr = 1'b0, cpu_rd = 1'b1;
    logic [15:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_rd;
    logic [15:0] mem [0:255];

    int vec = 0, miss = 0;

    cpu_dbg_ctrl #(.AWIDTH(16), .DWIDTH(16), .RST_CYCLES(RC), .BOOT_RUN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
        .halted_o(halted), .cpu_en_o(cpu_en), .cpu_rst_o(cpu_rst),
        .cpu_raddr_i(cpu_raddr), .cpu_waddr_i(cpu_waddr), .cpu_wdata_i(cpu_wdata),
        .cpu_wr_i(cpu_wr), .cpu_rd_i(cpu_rd),
        .mem_raddr_o(mem_raddr), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
        .mem_wr_o(mem_wr), .mem_rd_o(mem_rd), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous memory: read data appears the cycle after the address
    always @(posedge clk) begin
        if (mem_wr) mem[mem_waddr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_raddr[7:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // issue one command and wait for its response; lat counts cycles from acceptance to response
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output int en, output int wr);
        int w;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        w = 0;
        #1;
        while (!cmd_ready && w < 50) begin cyc(); #1; w++; end
        chk("accept", 32'(cmd_ready), 1);
        cyc();
        cmd_valid = 1'b0;
        lat = 1; en = 0; wr = 0;
        while (!rsp_valid && lat < 300) begin
            if (cpu_en) en++;
            if (mem_wr) wr++;
            cyc();
            lat++;
        end
    endtask

    task automatic step_seq(input logic [15:0] d, input int n);
        int en, w;
        cpu_raddr = 16'h0ABC;
        cmd_valid = 1'b1; cmd_op = STP; cmd_addr = 16'h5555; cmd_data = d;
        #1;
        chk("step_ready", 32'(cmd_ready), 1);
        cyc();
        cmd_valid = 1'b0;
        chk("resume_en", 32'(cpu_en), 0);
        chk("resume_raddr", 32'(mem_raddr), 32'h0ABC);
        en = 0; w = 0;
        while (!rsp_valid && w < 100) begin
            if (cpu_en) en++;
            cyc();
            w++;
        end
        chk("step_en_cycles", en, n);
        chk("step_lat", w, n + 1);
        chk("step_err", 32'(rsp_err), 0);
        chk("step_halted", 32'(halted), 1);
        chk("step_en_after", 32'(cpu_en), 0);
    endtask

    typedef struct {
        bit         h;
        logic [2:0] op;
        bit         err;
        int         lat;
        int         en;
        bit         ha;
    } vec_t;

    vec_t        tbl [14];
    bit          mh;
    int          lat, en, wr, n, e_lat, e_en, e_wr, cnt_r, cnt_w, cnt_v;
    bit          e_err, e_h;
    logic [2:0]  op;
    logic [15:0] a, d;
    logic [15:0] shadow [16];
    bit          known [16];

    initial begin
        tbl[0]  = '{0, NOP,  0, 1, 0, 0};
        tbl[1]  = '{0, BAD,  0, 1, 0, 0};
        tbl[2]  = '{0, RD,   1, 1, 0, 0};
        tbl[3]  = '{0, WR,   1, 1, 0, 0};
        tbl[4]  = '{0, STP,  1, 1, 0, 0};
        tbl[5]  = '{0, RUNC, 1, 1, 0, 0};
        tbl[6]  = '{0, HLT,  0, 1, 0, 1};
        tbl[7]  = '{1, NOP,  0, 1, 0, 1};
        tbl[8]  = '{1, HLT,  0, 1, 0, 1};
        tbl[9]  = '{1, BAD,  0, 1, 0, 1};
        tbl[10] = '{1, RUNC, 0, 2, 0, 0};
        tbl[11] = '{1, STP,  0, 4, 2, 1};
        tbl[12] = '{0, RST,  0, RC + 1, RC, 1};
        tbl[13] = '{1, RST,  0, RC + 1, RC, 1};
        for (int i = 0; i < 16; i++) known[i] = 1'b0;

        // reset and boot into run
        cpu_wr = 1'b1;
        repeat (3) cyc();
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_cpu_en", 32'(cpu_en), 1);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("mem_rd", 32'(mem_rd), 1);
        cpu_wr = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (cpu_rst && n < 20) begin n++; cyc(); end
        chk("boot_rst_cycles", n, RC);
        chk("boot_resume_en", 32'(cpu_en), 0);
        chk("boot_resume_raddr", 32'(mem_raddr), 32'h1234);
        cyc();
        chk("boot_run_en", 32'(cpu_en), 1);
        chk("boot_run_ready", 32'(cmd_ready), 1);
        chk("boot_no_rsp", 32'(rsp_valid), 0);

        // HALT in RUN: CPU write in the accept cycle passes, none afterwards
        cpu_wr = 1'b1;
        cmd_valid = 1'b1; cmd_op = HLT;
        #1;
        chk("halt_ready", 32'(cmd_ready), 1);
        chk("halt_cpu_wr_t", 32'(mem_wr), 1);
        chk("halt_cpu_waddr", 32'(mem_waddr), 32'h00F0);
        cyc();
        cmd_valid = 1'b0;
        chk("halt_cpu_wr_t1", 32'(mem_wr), 0);
        chk("halt_en", 32'(cpu_en), 0);
        chk("halt_rsp", 32'(rsp_valid), 1);
        chk("halt_err", 32'(rsp_err), 0);
        chk("halt_halted", 32'(halted), 1);
        cpu_wr = 1'b0;

        // host WRITE then READ
        cmd_valid = 1'b1; cmd_op = WR; cmd_addr = 16'h0040; cmd_data = 16'hBEEF;
        #1;
        chk("wr_ready", 32'(cmd_ready), 1);
        cyc();
        cmd_valid = 1'b0;
        chk("wr_strobe", 32'(mem_wr), 1);
        chk("wr_addr", 32'(mem_waddr), 32'h0040);
        chk("wr_data", 32'(mem_wdata), 32'hBEEF);
        chk("wr_busy", 32'(cmd_ready), 0);
        cyc();
        chk("wr_rsp", 32'(rsp_valid), 1);
        chk("wr_err", 32'(rsp_err), 0);
        chk("wr_strobe_end", 32'(mem_wr), 0);
        issue(RD, 16'h0040, 16'h0, lat, en, wr);
        chk("rd_lat", lat, 3);
        chk("rd_err", 32'(rsp_err), 0);
        chk("rd_data", 32'(rsp_data), 32'hBEEF);
        chk("rd_ready_again", 32'(cmd_ready), 1);
        issue(NOP, 16'h0, 16'h0, lat, en, wr);
        chk("rd_data_hold", 32'(rsp_data), 32'hBEEF);

        step_seq(16'd3, 3);
        step_seq(16'd0, 1);

        // long STEP aborted by HALT
        cmd_valid = 1'b1; cmd_op = STP; cmd_data = 16'h1000;
        #1;
        chk("lstep_ready", 32'(cmd_ready), 1);
        cyc();
        cmd_valid = 1'b0;
        repeat (4) cyc();
        cmd_valid = 1'b1; cmd_op = RD;
        #1;
        chk("step_stall", 32'(cmd_ready), 0);
        chk("step_running", 32'(cpu_en), 1);
        cmd_op = HLT;
        #1;
        chk("step_halt_ready", 32'(cmd_ready), 1);
        cyc();
        cmd_valid = 1'b0;
        chk("abort_en", 32'(cpu_en), 0);
        chk("abort_rsp", 32'(rsp_valid), 1);
        chk("abort_err", 32'(rsp_err), 0);
        chk("abort_halted", 32'(halted), 1);
        cnt_v = 0;
        repeat (30) begin cyc(); if (rsp_valid) cnt_v++; end
        chk("abort_single_rsp", cnt_v, 0);

        // rst_n pulse in the middle of a host READ
        cmd_valid = 1'b1; cmd_op = RD; cmd_addr = 16'h0003;
        #1;
        chk("mid_rd_ready", 32'(cmd_ready), 1);
        cyc();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        cpu_wr = 1'b1;
        #1;
        chk("mid_rd_wr", 32'(mem_wr), 0);
        cyc();
        rst_n = 1'b1;
        chk("mid_rd_no_rsp", 32'(rsp_valid), 0);
        chk("mid_rd_cpu_rst", 32'(cpu_rst), 1);
        chk("mid_rd_ready0", 32'(cmd_ready), 0);
        chk("mid_rd_data_clr", 32'(rsp_data), 0);
        cnt_r = 0; cnt_w = 0; cnt_v = 0;
        repeat (RC + 1) begin
            if (cpu_rst) cnt_r++;
            if (mem_wr) cnt_w++;
            if (rsp_valid) cnt_v++;
            cyc();
        end
        chk("mid_rd_rst_cycles", cnt_r, RC);
        chk("mid_rd_wr_blocked", cnt_w, 0);
        chk("mid_rd_rsp_none", cnt_v, 0);
        chk("mid_rd_run_en", 32'(cpu_en), 1);
        chk("mid_rd_run_wr", 32'(mem_wr), 1);
        cpu_wr = 1'b0;
        cnt_v = 0;
        repeat (10) begin cyc(); if (rsp_valid) cnt_v++; end
        chk("mid_rd_rsp_later", cnt_v, 0);
        mh = 1'b0;

        // command/state response table
        for (int i = 0; i < 14; i++) begin
            if (mh != tbl[i].h) begin
                issue(tbl[i].h ? HLT : RUNC, 16'h0, 16'h0, lat, en, wr);
                chk("tbl_prep_lat", lat, tbl[i].h ? 1 : 2);
            end
            issue(tbl[i].op, 16'h0003, 16'd2, lat, en, wr);
            chk("tbl_lat", lat, tbl[i].lat);
            chk("tbl_err", 32'(rsp_err), 32'(tbl[i].err));
            chk("tbl_en_cycles", en, tbl[i].en);
            chk("tbl_wr", wr, 0);
            chk("tbl_halted", 32'(halted), 32'(tbl[i].ha));
            chk("tbl_cpu_en", 32'(cpu_en), 32'(!tbl[i].ha));
            mh = tbl[i].ha;
        end

        // randomized command stream against the behavioural model
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 16'($urandom_range(0, 15));
            d = (op == WR) ? 16'($urandom) : 16'($urandom_range(0, 5));
            cpu_raddr = 16'($urandom);
            n = (d == 16'd0) ? 1 : int'(d);
            e_err = 1'b0; e_en = 0; e_wr = 0; e_h = mh; e_lat = 1;
            if (op == RST) begin
                e_lat = RC + 1; e_en = RC; e_h = 1'b1;
            end else if (!mh) begin
                e_h = (op == HLT);
                e_err = op inside {RUNC, STP, RD, WR};
            end else begin
                case (op)
                    RUNC: begin e_lat = 2; e_h = 1'b0; end
                    STP:  begin e_lat = n + 2; e_en = n; end
                    RD:   e_lat = 3;
                    WR:   begin e_lat = 2; e_wr = 1; end
                    default: e_lat = 1;
                endcase
            end
            issue(op, a, d, lat, en, wr);
            chk("rnd_lat", lat, e_lat);
            chk("rnd_err", 32'(rsp_err), 32'(e_err));
            chk("rnd_en_cycles", en, e_en);
            chk("rnd_wr", wr, e_wr);
            chk("rnd_halted", 32'(halted), 32'(e_h));
            if (mh && op == RD && known[a[3:0]]) chk("rnd_rd_data", 32'(rsp_data), 32'(shadow[a[3:0]]));
            if (mh && op == WR) begin
                shadow[a[3:0]] = d;
                known[a[3:0]] = 1'b1;
            end
            mh = e_h;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/cpu_dbg_ctrl.md
# cpu_dbg_ctrl

Debug and run controller for the 16-bit `cpu`. It sits between the CPU core, its single synchronous memory and a host command port. It sequences the CPU through reset, run, halt and N-cycle single-step using a clock-enable. While the CPU is halted, it lends the memory port to the host for word reads and writes.

## Interface
Parameters:
- `AWIDTH`, 16, memory address width.
- `DWIDTH`, 16, memory data width.
- `RST_CYCLES`, 4, number of cycles `cpu_rst_o` is held per CPU reset (1..255).
- `BOOT_RUN`, 1, selects the state after the reset sequence: 1 = run, 0 = halted.

Ports:
- `clk` in 1: single clock for the block.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid_i` in 1, `cmd_ready_o` out 1: host command handshake. A command transfers on a cycle where both are high.
- `cmd_op_i` in 3: 0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 RESET, 5 READ, 6 WRITE, 7 treated as NOP.
- `cmd_addr_i` in AWIDTH, `cmd_data_i` in DWIDTH: command operands.
- `rsp_valid_o` out 1: one-cycle pulse marking command completion.
- `rsp_err_o` out 1, `rsp_data_o` out DWIDTH: completion status and read data.
- `halted_o` out 1: high in the HALTED state.
- `cpu_en_o` out 1: CPU clock-enable.
- `cpu_rst_o` out 1: CPU synchronous reset, active-high.
- `cpu_raddr_i`, `cpu_waddr_i`, `cpu_wdata_i`, `cpu_wr_i`, `cpu_rd_i`: CPU memory request; widths per parameters.
- `mem_raddr_o`, `mem_waddr_o`, `mem_wdata_o`, `mem_wr_o`, `mem_rd_o`, `mem_rdata_i`: memory port. `mem_rdata_i` is valid the cycle after the address is driven.

## Operation
States: CRST, RESUME, RUN, HALT, STEP, HRD, HRD2, HWR.

Memory mux:
- `cpu_en_o`=1 or state RESUME: memory outputs follow the CPU inputs, except that `mem_wr_o` = `cpu_wr_i & cpu_en_o`.
- Any other state: memory outputs are host-driven. `mem_wr_o`=1 only in HWR.

CRST:
- `cpu_rst_o`=1, `cpu_en_o`=1, `mem_wr_o`=0. An 8-bit counter runs RST_CYCLES cycles.
- After the count, go to RESUME if the entry came from `rst_n` and BOOT_RUN=1; otherwise go to HALT.
- The RESET command enters CRST and completes in HALT with a response.

RESUME:
- One cycle with `cpu_en_o`=0 and `mem_raddr_o`=`cpu_raddr_i`.
- This replays the CPU's in-flight fetch so `mem_rdata_i` is correct when the CPU re-enables.
- Next state is RUN or STEP.

RUN:
- `cpu_en_o`=1, `cmd_ready_o`=1.
- HALT: `cpu_en_o`=0 from the next cycle; state becomes HALT; response with err=0.
- RESET: enter CRST.
- NOP: response with err=0.
- READ, WRITE, STEP, RUN: no action; response with err=1.

HALT:
- `cpu_en_o`=0, `cmd_ready_o`=1.
- RUN: RESUME, then RUN; response on entry to RUN.
- STEP: the 16-bit counter is loaded with `cmd_data_i` (0 is treated as 1); RESUME, then STEP.
- READ: go to HRD. WRITE: go to HWR.
- HALT and NOP: response with err=0.

STEP:
- `cpu_en_o`=1 for exactly N cycles, then HALT with a response (err=0).
- `cmd_ready_o`=1 only for HALT. A HALT here aborts the step: `cpu_en_o`=0 next cycle, response err=0, no second response for the step.
- Any other command has `cmd_ready_o`=0 and is stalled.

Host access:
- HRD: drive `mem_raddr_o`=latched addr for one cycle. HRD2: capture `mem_rdata_i` into `rsp_data_o`, respond, return to HALT.
- HWR: drive waddr/wdata with `mem_wr_o`=1 for one cycle, respond, return to HALT.
- `cmd_ready_o`=0 in CRST, RESUME, HRD, HRD2 and HWR.

Other rules:
- `rsp_data_o` holds its value until the next READ completes.
- `mem_rd_o`=1 always.

## Timing
- Reset values while `rst_n`=0: state CRST, counter cleared, `cpu_rst_o`=1, `cpu_en_o`=1, `mem_wr_o`=0, `cmd_ready_o`=0, `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_data_o`=0, `halted_o`=0.
- `rst_n` release: `cpu_rst_o` stays high RST_CYCLES further cycles. With BOOT_RUN=1, RESUME follows and `cpu_en_o` rises one cycle later.
- READ accepted at cycle t: address driven t+1, data captured at the end of t+2, `rsp_valid_o` high at t+3, `cmd_ready_o` high again at t+3.
- WRITE accepted at t: write strobe at t+1, response at t+2.
- STEP N accepted at t: RESUME at t+1, `cpu_en_o` high t+2..t+N+1, response at t+N+2 with `halted_o`=1.
- HALT accepted at t in RUN: `cpu_en_o`=0 from t+1; a CPU write asserted at t completes, none from t+1.
- `rst_n` low in any state, including mid-READ or mid-STEP: immediate return to CRST on the next edge and no response for the pending command.

## Test plan
- Reset, BOOT_RUN=1, RST_CYCLES=4 -> `cpu_rst_o` high 4 cycles after release, 1 RESUME cycle, then `cpu_en_o`=1.
- HALT, then WRITE addr 0x0040 data 0xBEEF, then READ 0x0040 -> `mem_wr_o` pulse at 0x0040; read response 0xBEEF, err=0, at t+3.
- STEP with data 3, then with data 0 -> `cpu_en_o` high exactly 3 cycles, then exactly 1 cycle; RESUME replays `cpu_raddr_i` before each.
- READ while in RUN -> response err=1, no host memory cycle, CPU stays enabled.
- STEP 0x1000 followed by HALT 5 cycles later -> `cpu_en_o` low the next cycle, exactly one response.
- `rst_n` pulsed low during HRD -> no response, CRST sequence restarts, `mem_wr_o`=0 throughout.
